// File: rtl/timer_device_if.sv
// Bridge-bus link between the processor bridge (master) and a timer (slave).
// Dout is combinational on Addr in the slave.
interface timer_device_if;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (output Addr, output WE, output Din, input Dout);
    modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/timer_device.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// Word map: 0=CTRL, 1=PRESET, 2=COUNT (read-only), 3=reserved.
module timer_device #(
    parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    timer_device_if.slave bus,
    output logic          IRQ
);
    typedef enum logic [1:0] {S_IDLE, S_CNT, S_INT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;

    logic enable, auto_reload, irq_mask;
    logic wr_ctrl, wr_preset;

    assign enable      = ctrl_q[0];
    assign auto_reload = (ctrl_q[2:1] == 2'b01);
    assign irq_mask    = ctrl_q[3];
    assign wr_ctrl     = bus.WE && (bus.Addr == 2'd0);
    assign wr_preset   = bus.WE && (bus.Addr == 2'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            preset_q <= PRESET_RST;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        // Clear first so an expiry on this same edge still sets the flag.
        if (!auto_reload && (wr_ctrl || wr_preset)) flag_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    count_d = preset_q;
                    state_d = S_CNT;
                end
            end
            S_CNT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = '0;
                    flag_d  = 1'b1;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                if (auto_reload) flag_d = 1'b0;
                else             ctrl_d[0] = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Bus writes applied last so a CTRL write overrides the enable auto-clear.
        if (wr_ctrl)   ctrl_d   = bus.Din[3:0];
        if (wr_preset) preset_d = bus.Din;
    end

    always_comb begin
        case (bus.Addr)
            2'd0:    bus.Dout = {28'b0, ctrl_q};
            2'd1:    bus.Dout = preset_q;
            2'd2:    bus.Dout = count_q;
            default: bus.Dout = '0;
        endcase
    end

    assign IRQ = flag_q & irq_mask;
endmodule

// File: tb/tb_timer_device.sv
// Directed self-checking bench for timer_device: reset, one-shot, auto-reload,
// mask, disable/re-enable and asynchronous reset.
module tb_timer_device;
    localparam logic [31:0] PRST = 32'hA5A5_0003;

    logic clk;
    logic reset;
    logic IRQ;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    timer_device_if bus ();

    timer_device #(.PRESET_RST(PRST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        bus.Addr = a;
        #1;
        chk(tag, bus.Dout, exp);
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        chk(tag, {31'b0, IRQ}, {31'b0, exp});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.Addr = a;
        bus.WE   = 1'b1;
        bus.Din  = d;
        step();
        bus.WE   = 1'b0;
        bus.Din  = '0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.Addr = 2'd0;
        bus.WE   = 1'b0;
        bus.Din  = '0;
        #12 reset = 1'b0;
        step();

        // 1: reset values, COUNT is read-only
        rd(2'd0, 32'h0, "rst_ctrl");
        rd(2'd1, PRST, "rst_preset");
        rd(2'd2, 32'h0, "rst_count");
        rd(2'd3, 32'h0, "rst_rsvd");
        chk_irq(1'b0, "rst_irq");
        wr(2'd2, 32'd5);
        rd(2'd2, 32'h0, "count_ro");
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, 32'h0, "rsvd_ro");

        // 2: one-shot, PRESET=3
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hFFFF_FFF9);
        rd(2'd0, 32'h9, "os_ctrl_trunc");
        for (int i = 1; i <= 4; i++) begin
            step();
            rd(2'd2, 32'(4 - i), $sformatf("os_count_e%0d", i));
            chk_irq(i == 4, $sformatf("os_irq_e%0d", i));
        end
        step();
        rd(2'd0, 32'h8, "os_ctrl_autoclr");
        chk_irq(1'b1, "os_irq_hold_e5");
        step();
        chk_irq(1'b1, "os_irq_hold_e6");
        wr(2'd0, 32'h8);
        chk_irq(1'b0, "os_irq_cleared");

        // 3: auto-reload, PRESET=2, period 4
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        for (int i = 0; i < 12; i++) begin
            step();
            rd(2'd2, (i % 4 == 0) ? 32'd2 : (i % 4 == 1) ? 32'd1 : 32'd0,
               $sformatf("ar_count_%0d", i));
            chk_irq((i % 4) == 2, $sformatf("ar_irq_%0d", i));
        end
        step();
        rd(2'd2, 32'd2, "ar_reload");
        wr(2'd0, 32'h8);
        step();
        rd(2'd2, 32'd1, "ar_stop_hold");
        chk_irq(1'b0, "ar_stop_irq");

        // 4: masked expiry, then clearing write and unmasked run
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);
        step();
        chk_irq(1'b0, "mask_e1");
        step();
        rd(2'd2, 32'd0, "mask_count_e2");
        chk_irq(1'b0, "mask_e2");
        step();
        rd(2'd0, 32'h0, "mask_ctrl_autoclr");
        wr(2'd0, 32'h9);
        chk_irq(1'b0, "mask_no_spurious");
        step();
        rd(2'd2, 32'd1, "mask_count_e1");
        chk_irq(1'b0, "mask_run_e1");
        step();
        chk_irq(1'b1, "mask_run_e2");
        step();

        // 5: disable freezes COUNT, re-enable reloads
        wr(2'd1, 32'd10);
        chk_irq(1'b0, "dis_preset_clears");
        wr(2'd0, 32'h9);
        for (int i = 1; i <= 4; i++) step();
        rd(2'd2, 32'd7, "dis_count7");
        wr(2'd0, 32'h0);
        rd(2'd2, 32'd6, "dis_count6");
        for (int i = 1; i <= 5; i++) begin
            step();
            rd(2'd2, 32'd6, $sformatf("dis_hold_%0d", i));
        end
        wr(2'd0, 32'h9);
        rd(2'd2, 32'd6, "reen_e0");
        for (int i = 1; i <= 11; i++) begin
            step();
            rd(2'd2, (i <= 10) ? 32'(11 - i) : 32'd0, $sformatf("reen_count_%0d", i));
            chk_irq(i == 11, $sformatf("reen_irq_%0d", i));
        end
        step();

        // 6: asynchronous reset mid-count
        wr(2'd0, 32'h9);
        for (int i = 1; i <= 4; i++) step();
        rd(2'd2, 32'd7, "ares_count7");
        #3 reset = 1'b1;
        #1;
        rd(2'd2, 32'd0, "ares_count");
        rd(2'd0, 32'd0, "ares_ctrl");
        rd(2'd1, PRST, "ares_preset");
        chk_irq(1'b0, "ares_irq");
        #5 reset = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/timer_device.md
Name: timer_device

Overview:
- Memory-mapped countdown timer: the responder side of the processor's bridge bus.
- Two instances sit behind the bridge, at 0x0000_7f00–0x0000_7f0b and 0x0000_7f10–0x0000_7f1b.
- The memory stage issues word loads/stores; the bridge decodes the address, drives Addr/WE/Din and returns Dout as PrRD.
- IRQ feeds one HWInt line of CP0.

Parameters:
- PRESET_RST, 32'h0000_0000, reset value of the PRESET register.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- Addr  in  2  word select (PrAddr[3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- WE  in  1  write strobe from bridge, already qualified by address decode and IntReq
- Din  in  32  write data
- Dout  out  32  read data, combinational on Addr
- IRQ  out  1  interrupt request to CP0 HWInt

Behaviour:
- Registers:
  - CTRL[3:0]: bit0 Enable, bits2:1 Mode (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask, 1=allow).
  - PRESET[31:0]; COUNT[31:0]; irq_flag; state.
- Reset (async): CTRL=0, PRESET=PRESET_RST, COUNT=0, irq_flag=0, state=IDLE. IRQ=0, Dout follows Addr with these values.
- Read, combinational, zero latency:
  - Addr 0 → {28'b0,CTRL}
  - Addr 1 → PRESET
  - Addr 2 → COUNT
  - Addr 3 → 0
- Write, on the clk edge with WE=1:
  - Addr 0 → CTRL<=Din[3:0], upper bits discarded.
  - Addr 1 → PRESET<=Din.
  - Addr 2/3 → ignored (COUNT is read-only; the CPU raises AdES before such a store).
- FSM, one transition per edge:
  - IDLE: if Enable → COUNT<=PRESET, go CNT. Otherwise hold; COUNT holds.
  - CNT:
    - If Enable=0 → IDLE, COUNT holds.
    - Else if COUNT>1 → COUNT<=COUNT-1.
    - Else (COUNT is 0 or 1) → COUNT<=0, irq_flag<=1, go INT.
  - INT, Mode 00: Enable<=0, go IDLE; irq_flag stays set.
  - INT, Mode 01: irq_flag<=0, go IDLE with Enable still 1, so the counter reloads on the next edge.
- irq_flag clear rules:
  - Mode 00: cleared by any WE write to Addr 0 or 1.
  - Mode 01: self-clears after the one cycle spent in INT.
- IRQ = irq_flag & IM, combinational from registers; no glitch path from Din.
- Timing:
  - Enabling write at edge E0 → IRQ rises after edge E0+PRESET+1 (PRESET≥1).
  - PRESET=0 behaves like PRESET=1: IRQ rises after E0+2.
  - Auto-reload period is PRESET+2 cycles; IRQ pulse width is 1 cycle.
- Simultaneous events:
  - A CTRL write in the same cycle as the INT-state Enable auto-clear: the written CTRL value wins.
  - A clearing write in the same cycle as CNT→INT entry: the set wins, so an expiry event is never lost.
  - A PRESET write during CNT does not alter COUNT; it takes effect at the next reload.
  - A CTRL write clearing Enable during CNT freezes COUNT; re-enabling reloads COUNT from PRESET (no resume).
- Reset asserted mid-count → immediate return to reset values, independent of clk.
- COUNT never wraps below 0; decrement is 32-bit unsigned.

Test Plan:
1. Reset, then read Addr 0/1/2/3 → 0, PRESET_RST, 0, 0; IRQ=0. Write Addr 2 = 5 → COUNT still reads 0.
2. One-shot:
   - Write PRESET=3, then CTRL=4'b1001 at E0.
   - COUNT reads 3, 2, 1, 0 after E1..E4; IRQ=1 after E4.
   - After E5, CTRL reads 4'b1000; IRQ stays 1.
   - Write CTRL=4'b1000 → IRQ=0 next edge.
3. Auto-reload: PRESET=2, CTRL=4'b1011 → IRQ one-cycle pulses every 4 cycles; COUNT sequence 2,1,0,0,2,1,0,… across ≥3 periods.
4. Mask: PRESET=1, CTRL=4'b0001 → after expiry the internal flag is set but IRQ=0. Writing CTRL=4'b1001 clears the flag, so no spurious IRQ is seen on that write, and the new run then raises IRQ after E0+2.
5. Disable/resume: PRESET=10, enable; at COUNT=6 write CTRL=0 → COUNT holds 6 for 5 cycles. Re-enable → COUNT reloads to 10; IRQ after a further 11 edges.
6. Async reset: assert reset between clock edges during CNT with COUNT=7 → COUNT, CTRL and IRQ become 0 immediately, before the next clk edge.
